// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment lookup for the seven-segment scan driver.
// Segment vectors are indexed [0:6] = a..g, active low.
package seg7_pkg;

  localparam logic [0:6] SegBlank = 7'b1111111;

  function automatic logic [0:6] hex_to_seg(input logic [3:0] hex);
    logic [0:6] s;
    case (hex)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0001100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value/control inputs and display outputs of the scan driver, bundled as one port.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lzb;
  logic [0:6]              seg;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    pending;
  logic                    frame;

  modport master (
    output value, load, blank_mask, lzb,
    input  seg, digit_en, pending, frame
  );

  modport slave (
    input  value, load, blank_mask, lzb,
    output seg, digit_en, pending, frame
  );

endinterface

// File: rtl/dec_onehot.sv
// Binary index to one-hot decoder with enable.
module dec_onehot #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]        idx,
  input  logic                en,
  output logic [(1<<N)-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display driver: prescaled digit scan, frame-aligned value update,
// per-digit masking and leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV        = 50000
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned IdxW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned ValW = 4 * NUM_DIGITS;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]        cnt_q;
  logic [IdxW-1:0]        idx_q;
  logic [ValW-1:0]        active_q, pend_q;
  logic                   pending_q, frame_q;
  logic [0:6]             seg_q, seg_d;
  logic [NUM_DIGITS-1:0]  digit_en_q;
  logic [(1<<IdxW)-1:0]   onehot;
  logic                   tick, wrap;

  assign tick = (cnt_q == CntMax);
  assign wrap = tick && (idx_q == IdxMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= tick ? '0 : cnt_q + 1'b1;
      if (tick) idx_q <= wrap ? '0 : idx_q + 1'b1;
      frame_q <= wrap;
    end
  end

  // Active digits change only at the wrap so a frame never mixes old and new values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q  <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
    end else if (wrap) begin
      active_q  <= bus.load ? bus.value : (pending_q ? pend_q : active_q);
      pending_q <= 1'b0;
    end else if (bus.load) begin
      pend_q    <= bus.value;
      pending_q <= 1'b1;
    end
  end

  always_comb begin
    logic [3:0] digit;
    logic       mask_bit;
    logic       upper_zero;
    logic       blank;
    digit      = '0;
    mask_bit   = 1'b0;
    upper_zero = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        digit    = active_q[4*k +: 4];
        mask_bit = bus.blank_mask[k];
      end
      if (IdxW'(k) >= idx_q && active_q[4*k +: 4] != 4'h0) upper_zero = 1'b0;
    end
    blank = mask_bit | (bus.lzb & upper_zero & (idx_q != '0));
    seg_d = blank ? SegBlank : hex_to_seg(digit);
  end

  dec_onehot #(
    .N(IdxW)
  ) u_dec (
    .idx    (idx_q),
    .en     (1'b1),
    .onehot (onehot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q      <= SegBlank;
      digit_en_q <= '0;
    end else begin
      seg_q      <= seg_d;
      digit_en_q <= onehot[NUM_DIGITS-1:0];
    end
  end

  assign bus.seg      = seg_q;
  assign bus.digit_en = digit_en_q;
  assign bus.pending  = pending_q;
  assign bus.frame    = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4 cycles per slot) against a
// cycle-count based model of scan position, frame-aligned updates and blanking rules.
module tb_seg7_scan_driver;

  localparam int unsigned ND       = 4;
  localparam int unsigned DV       = 4;
  localparam int unsigned FrameLen = ND * DV;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .DIV        (DV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model state: c counts clock edges since reset release.
  int          c;
  logic [15:0] m_active, m_pend;
  logic        m_pv;
  logic [0:6]  hex_tbl [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] v);
    int         slot;
    logic       wrap;
    logic       blank;
    logic [3:0] nib;
    logic [0:6] e_seg;
    logic [3:0] e_en;
    bus.load  = ld;
    bus.value = v;
    slot  = (c / DV) % ND;
    wrap  = (c % FrameLen) == FrameLen - 1;
    nib   = 4'((m_active >> (4 * slot)) & 16'hF);
    blank = bus.blank_mask[slot] || (bus.lzb && slot != 0 && (m_active >> (4 * slot)) == 0);
    e_seg = blank ? 7'b1111111 : hex_tbl[nib];
    e_en  = 4'(1 << slot);
    if (wrap) begin
      m_active = ld ? v : (m_pv ? m_pend : m_active);
      m_pv     = 1'b0;
    end else if (ld) begin
      m_pend = v;
      m_pv   = 1'b1;
    end
    @(posedge clk);
    #1;
    c++;
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("digit_en", 32'(bus.digit_en), 32'(e_en));
    check("pending", 32'(bus.pending), 32'(m_pv));
    check("frame", 32'(bus.frame), 32'(wrap));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
  endtask

  task automatic run_to_phase(input int phase);
    for (int i = 0; i < FrameLen && (c % FrameLen) != phase; i++) step(1'b0, 16'h0000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, 32'(bus.seg), 32'h7F);
    check({tag, "_digit_en"}, 32'(bus.digit_en), 32'h0);
    check({tag, "_pending"}, 32'(bus.pending), 32'h0);
    check({tag, "_frame"}, 32'(bus.frame), 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst      = 1'b0;
    c        = 0;
    m_active = '0;
    m_pend   = '0;
    m_pv     = 1'b0;
  endtask

  initial begin
    hex_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    rst            = 1'b1;
    bus.load       = 1'b0;
    bus.value      = '0;
    bus.blank_mask = '0;
    bus.lzb        = 1'b0;
    c              = 0;

    // Reset values, then idle scan of zeros with frame pulses.
    @(posedge clk);
    #1;
    check_reset_outputs("por");
    release_reset();
    run(2 * FrameLen);

    // Load mid-frame: pending until wrap, then F,3,A,1.
    run_to_phase(5);
    step(1'b1, 16'h1A3F);
    run(2 * FrameLen);

    // Load on the wrap tick goes straight to the active register.
    run_to_phase(FrameLen - 1);
    step(1'b1, 16'h0007);
    run(FrameLen + 2);

    // Leading-zero blanking on and off.
    step(1'b1, 16'h0050);
    bus.lzb = 1'b1;
    run(2 * FrameLen);
    bus.lzb = 1'b0;
    run(FrameLen);

    // Live mask on digit 1, including a double load before the wrap.
    run_to_phase(2);
    step(1'b1, 16'hFFFF);
    step(1'b1, 16'h1234);
    bus.blank_mask = 4'b0010;
    run(2 * FrameLen);
    bus.blank_mask = 4'b0000;

    // Randomised loads, masks and blanking.
    for (int i = 0; i < 300; i++) begin
      logic        ld;
      logic [15:0] v;
      if ($urandom_range(0, 7) == 0) bus.blank_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bus.lzb = 1'($urandom);
      ld = ($urandom_range(0, 9) == 0);
      v  = 16'($urandom) >> $urandom_range(0, 15);
      step(ld, v);
    end
    bus.blank_mask = '0;
    bus.lzb        = 1'b0;

    // Reset mid-frame with a pending value: it must never appear.
    run_to_phase(6);
    step(1'b1, 16'hBEEF);
    run(3);
    check("pending_before_reset", 32'(bus.pending), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    check_reset_outputs("held");
    release_reset();
    run(2 * FrameLen);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of hex digits scanned (legal 1..8).
REQ-002 The block SHALL have parameter DIV, default 50000, giving Clock cycles per digit slot (legal >= 1).
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 Clock  input  1  rising-edge system clock.
REQ-005 Reset  input  1  asynchronous active-high reset.
REQ-006 Value  input  4*NUM_DIGITS  hex digits; digit k occupies bits [4k+3:4k], digit 0 least significant.
REQ-007 Load  input  1  single-cycle request to capture Value.
REQ-008 BlankMask  input  NUM_DIGITS  bit k high forces digit k blank.
REQ-009 LZB  input  1  leading-zero blanking enable.
REQ-010 Seg  output  7 (indexed [0:6])  active-low segments; Seg[0]=a ... Seg[6]=g.
REQ-011 DigitEn  output  NUM_DIGITS  active-high one-hot digit select.
REQ-012 Pending  output  1  high while a captured value awaits application.
REQ-013 Frame  output  1  one-cycle pulse when the scan wraps to digit 0.

Function
REQ-014 A prescaler SHALL count 0..DIV-1; a tick SHALL occur in the cycle it equals DIV-1, after which it returns to 0.
REQ-015 On each tick the digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0; DIV=1 SHALL advance every cycle.
REQ-016 Frame SHALL be asserted in the cycle after the index wraps to 0, for exactly one cycle.
REQ-017 Load SHALL copy Value into a pending register and set Pending in the next cycle.
REQ-018 The pending register SHALL be copied into the active register on the wrap tick (index NUM_DIGITS-1 -> 0), clearing Pending in the same edge, so no frame mixes old and new digits.
REQ-019 Load coinciding with a wrap tick SHALL place that cycle's Value directly into the active register; Pending SHALL end low.
REQ-020 A second Load before application SHALL overwrite the pending register; only the latest value is applied.
REQ-021 Seg and DigitEn SHALL be registered functions of the current index and active register, one cycle of latency after an index change.
REQ-022 DigitEn SHALL equal 1 << index at all times after the first post-reset cycle.
REQ-023 Hex encoding (Seg[0:6], 0=lit): 0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111 8:0000000 9:0001100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000.
REQ-024 A blank digit SHALL drive Seg = 1111111 while DigitEn still selects it.
REQ-025 Digit k SHALL be blank if BlankMask[k], or if LZB and digits k..NUM_DIGITS-1 of the active register are all zero and k != 0.
REQ-026 BlankMask and LZB SHALL be sampled live (not captured by Load).

Reset
REQ-027 Reset SHALL clear prescaler, index, active and pending registers, Pending and Frame to 0, set Seg to 1111111 and DigitEn to 0.
REQ-028 Reset asserted mid-frame or with Pending high SHALL discard the pending value; first post-reset cycle SHALL show digit 0 value 0.

Structure
REQ-029 The hex-to-segment table and blank pattern (7'b1111111) SHALL be constants/function in shared package seg7_pkg.
REQ-030 One-hot selection SHALL use a parametrised sub-module dec_onehot (N-bit index, enable, 2^N one-hot output).
REQ-031 Index width SHALL be clog2 of max(NUM_DIGITS,2).

Verification (NUM_DIGITS=4, DIV=4)
REQ-032 Reset release, no Load -> DigitEn cycles 0001,0010,0100,1000 every 4 cycles; Seg=0000001 on each; Frame pulses every 16 cycles.
REQ-033 Load Value=16'h1A3F mid-frame -> Pending=1 until wrap; next frame shows F,3,A,1 (0111000,0000110,0001000,1001111) on digits 0..3.
REQ-034 Load 16'h0007 on exact wrap-tick cycle -> Pending stays 0; next frame digit 0 = 0001111.
REQ-035 Active 16'h0050, LZB=1 -> digits 3,2 blank (1111111), digit 1=0100100, digit 0=0000001; LZB=0 -> digits 3,2 = 0000001.
REQ-036 BlankMask=4'b0010 with 16'h1234 -> digit 1 Seg=1111111, DigitEn still 0010 in its slot.
REQ-037 Reset asserted with Pending=1 mid-frame -> outputs immediately at reset values; pending value never displayed.
